// File: rtl/mul_reconstruct.sv
// mul_reconstruct: rebuilds a dividend from a divider's quotient, divisor and remainder.
// The dividend is quotient * divisor + remainder, computed by radix-2 shift-add over N cycles.
// The remainder preloads the accumulator, so no separate final add is needed.
// rem_err and div_zero flag inconsistent operand sets. Both are judged on the captured
// operands, not on the live inputs.
module mul_reconstruct #(
   parameter int unsigned N = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_input,
   input  logic [N-1:0]     quotient,
   input  logic [N-1:0]     divisor,
   input  logic [N-1:0]     remainder,
   output logic             busy,
   output logic             valid_output,
   output logic [2*N-1:0]   dividend_out,
   output logic             rem_err,
   output logic             div_zero
);

   localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CntLast = CW'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      quo_q, quo_d;
   logic [N-1:0]      div_q, div_d;
   logic [N-1:0]      rem_q, rem_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*N-1:0]    acc_q, acc_d;
   logic [2*N-1:0]    dividend_q, dividend_d;
   logic              rem_err_q, rem_err_d;
   logic              div_zero_q, div_zero_d;
   logic              accept;
   logic [2*N-1:0]    addend;
   logic [2*N-1:0]    acc_sum;

   // Partial product for the current quotient bit, and the updated accumulator.
   always_comb begin
      addend  = quo_q[cnt_q] ? ({{N{1'b0}}, div_q} << cnt_q) : '0;
      acc_sum = acc_q + addend;
   end

   // Next-state logic. New operands are taken only from IDLE or DONE, so RUN is never disturbed.
   always_comb begin
      state_d    = state_q;
      quo_d      = quo_q;
      div_d      = div_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      dividend_d = dividend_q;
      rem_err_d  = rem_err_q;
      div_zero_d = div_zero_q;
      accept     = 1'b0;

      case (state_q)
         StIdle: begin
            accept = valid_input;
         end
         StRun: begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CntLast) begin
               state_d    = StDone;
               dividend_d = acc_sum;
               rem_err_d  = (rem_q >= div_q);
               div_zero_d = (div_q == '0);
            end
         end
         StDone: begin
            state_d = StIdle;
            accept  = valid_input;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (accept) begin
         state_d = StRun;
         quo_d   = quotient;
         div_d   = divisor;
         rem_d   = remainder;
         cnt_d   = '0;
         acc_d   = {{N{1'b0}}, remainder};
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         quo_q      <= '0;
         div_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         dividend_q <= '0;
         rem_err_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         quo_q      <= quo_d;
         div_q      <= div_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         dividend_q <= dividend_d;
         rem_err_q  <= rem_err_d;
         div_zero_q <= div_zero_d;
      end
   end

   // Status outputs decode straight from the state. Results hold until the next completion.
   always_comb begin
      busy         = (state_q == StRun);
      valid_output = (state_q == StDone);
      dividend_out = dividend_q;
      rem_err      = rem_err_q;
      div_zero     = div_zero_q;
   end

endmodule

// File: tb/tb_mul_reconstruct.sv
// Directed bench for mul_reconstruct.
// A cycle-count model predicts every output on each falling edge.
// Literal values pin the model and the main results.
module tb_mul_reconstruct;

   localparam int unsigned N = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            valid_input = 1'b0;
   logic [N-1:0]    quotient = '0;
   logic [N-1:0]    divisor = '0;
   logic [N-1:0]    remainder = '0;
   logic            busy;
   logic            valid_output;
   logic [2*N-1:0]  dividend_out;
   logic            rem_err;
   logic            div_zero;

   int total = 0;
   int bad   = 0;

   mul_reconstruct #(.N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_input  (valid_input),
      .quotient     (quotient),
      .divisor      (divisor),
      .remainder    (remainder),
      .busy         (busy),
      .valid_output (valid_output),
      .dividend_out (dividend_out),
      .rem_err      (rem_err),
      .div_zero     (div_zero)
   );

   always #5 clk = ~clk;

   // Model state: m_left counts the remaining RUN cycles, and m_done marks the result cycle.
   int                m_left = 0;
   bit                m_done = 1'b0;
   longint unsigned   m_q = 0, m_d = 0, m_r = 0;
   logic [2*N-1:0]    m_div = '0;
   bit                m_re = 1'b0, m_dz = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_div  <= '0;
         m_re   <= 1'b0;
         m_dz   <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_div  <= (2*N)'(m_q * m_d + m_r);
            m_re   <= (m_r >= m_d);
            m_dz   <= (m_d == 0);
         end
      end else begin
         m_done <= 1'b0;
         if (valid_input) begin
            m_q    <= longint'(quotient);
            m_d    <= longint'(divisor);
            m_r    <= longint'(remainder);
            m_left <= N;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model, away from the active edge.
   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("valid_output", 64'(valid_output), 64'(m_done));
      chk("dividend_out", 64'(dividend_out), 64'(m_div));
      chk("rem_err", 64'(rem_err), 64'(m_re));
      chk("div_zero", 64'(div_zero), 64'(m_dz));
   end

   // Present one operand set; returns just after its acceptance edge.
   task automatic start(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r);
      @(posedge clk);
      #1;
      valid_input = 1'b1;
      quotient    = q;
      divisor     = d;
      remainder   = r;
      @(posedge clk);
      #1;
      valid_input = 1'b0;
   endtask

   // Edges from the last acceptance edge to the edge that samples valid_output=1.
   task automatic wait_done(input string name, output int lat);
      lat = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (valid_output === 1'b1) begin
            lat = k + 1;
            break;
         end
      end
      if (lat < 0) begin
         total++;
         bad++;
         $display("FAIL %s: timeout got no valid_output want pulse", name);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;

      // Reset state
      #7;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(valid_output), 64'd0);
      chk("rst_dividend", 64'(dividend_out), 64'd0);
      chk("rst_flags", 64'({rem_err, div_zero}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Basic reconstruction and its latency
      start(16'h1234, 16'h0100, 16'h0056);
      wait_done("wait_a", lat);
      chk("lat_a", 64'(lat), 64'd17);
      chk("mdl_a", 64'(m_div), 64'h0012_3456);
      chk("div_a", 64'(dividend_out), 64'h0012_3456);
      chk("flags_a", 64'({rem_err, div_zero}), 64'b00);

      // Largest operands: the result must not overflow
      start(16'hFFFF, 16'hFFFF, 16'hFFFE);
      wait_done("wait_b", lat);
      chk("mdl_b", 64'(m_div), 64'hFFFE_FFFF);
      chk("div_b", 64'(dividend_out), 64'hFFFE_FFFF);
      chk("flags_b", 64'({rem_err, div_zero}), 64'b00);

      // A divisor of zero still completes normally
      start(16'h0005, 16'h0000, 16'h0003);
      wait_done("wait_c", lat);
      chk("div_c", 64'(dividend_out), 64'h0000_0003);
      chk("flags_c", 64'({rem_err, div_zero}), 64'b11);

      // A re-pulse during RUN must be ignored
      start(16'h0002, 16'h0003, 16'h0001);
      repeat (4) @(posedge clk);
      #1;
      valid_input = 1'b1;
      quotient    = 16'h00FF;
      divisor     = 16'h00FF;
      remainder   = 16'h00FF;
      chk("busy_mid_031", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      valid_input = 1'b0;
      wait_done("wait_031", lat);
      chk("lat_031", 64'(lat), 64'd12);
      chk("div_031", 64'(dividend_out), 64'h0000_0007);

      // Reset mid-RUN aborts the operation, then a fresh operation proceeds
      start(16'hFFFF, 16'h1234, 16'h0001);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_valid", 64'(valid_output), 64'd0);
      chk("abort_dividend", 64'(dividend_out), 64'd0);
      chk("abort_flags", 64'({rem_err, div_zero}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (20) @(posedge clk);
      start(16'h0010, 16'h0010, 16'h0000);
      wait_done("wait_032", lat);
      chk("lat_032", 64'(lat), 64'd17);
      chk("div_032", 64'(dividend_out), 64'h0000_0100);

      // New operands presented in the DONE cycle are accepted back to back
      start(16'h0003, 16'h0007, 16'h0002);
      wait_done("wait_033a", lat);
      chk("lat_033a", 64'(lat), 64'd17);
      chk("div_033a", 64'(dividend_out), 64'h0000_0017);
      valid_input = 1'b1;
      quotient    = 16'h0100;
      divisor     = 16'h0010;
      remainder   = 16'h0020;
      @(posedge clk);
      #1;
      valid_input = 1'b0;
      wait_done("wait_033b", lat);
      chk("lat_033b", 64'(lat), 64'd17);
      chk("div_033b", 64'(dividend_out), 64'h0000_1020);
      chk("flags_033b", 64'({rem_err, div_zero}), 64'b10);

      repeat (4) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
